imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/cpu16_pkg.sv | 34 +++
 rtl/resp_fifo.sv | 74 +++++++
 rtl/imem_responder.sv | 138 +++++++++++++
 tb/tb_imem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// cpu16_pkg
// Shared definitions for the cpu16 front end (decoder, fetcher, instruction
// memory responder): instruction field positions, the NOP encoding, default
// fetch-path sizing and the response entry layout.
// No ports; import with "import cpu16_pkg::*;".
package cpu16_pkg;

    // The decoder treats opcode 4'h2 with all-zero operands as a no-op.
    localparam logic [15:0] NOP_WORD = 16'h2000;

    // Instruction field positions.
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 8;
    localparam int OPND_MSB = 7;
    localparam int OPND_LSB = 0;

    // Default fetch-path sizing.
    localparam int IMEM_LATENCY = 2;
    localparam int RSP_DEPTH    = 4;

    // One response as it travels through the pipeline and the FIFO (33 bits).
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] addr;
        logic        oob;
    } rsp_entry_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [15:0] insn);
        return insn[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo
// Response FIFO of DEPTH entries of rsp_entry_t. Pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two. flush empties it at the next edge and
// overrides a simultaneous push or pop.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write din at the tail
//   pop          drop the head entry
//   flush        discard every entry
//   full, empty  occupancy flags
//   head         entry at the head (meaningful only when !empty)
module resp_fifo
    import cpu16_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_entry_t din,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output rsp_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    rsp_entry_t         slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/imem_responder.sv
// imem_responder
// Instruction memory for the cpu16 fetch stage. Requests are accepted with a
// valid/ready handshake, the store is read in the acceptance cycle, the word
// travels through a LATENCY-cycle pipeline and lands in an in-order response
// FIFO. The outstanding count (in flight + queued) never exceeds DEPTH, so the
// FIFO can never overflow. flush drops everything; the store survives reset
// and flush and is written through the program-load port.
// Ports:
//   clk, CPU_RESET_n         clock, asynchronous active-low reset
//   req_valid/ready/addr     fetch request (16-bit word address)
//   rsp_valid/ready          fetch response handshake
//   rsp_data/addr/oob        instruction word, echoed address, out-of-range flag
//   flush                    discard all outstanding requests and responses
//   ld_en/addr/data          program-load write port
module imem_responder
    import cpu16_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = IMEM_LATENCY,
    parameter int DEPTH   = RSP_DEPTH
) (
    input  logic              clk,
    input  logic              CPU_RESET_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [15:0]       rsp_addr,
    output logic              rsp_oob,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [15:0]      store [2**ADDR_W];
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             consume;
    rsp_entry_t       in_entry;
    logic             push_valid;
    rsp_entry_t       push_entry;
    logic             fifo_full;
    logic             fifo_empty;
    rsp_entry_t       fifo_head;

    // Gated by reset so req_ready is low while reset is held, since count
    // alone would already read zero.
    assign req_ready = CPU_RESET_n && (count < CNT_W'(DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign consume   = rsp_valid && rsp_ready;

    // Combinational read: the load port writes at the edge, so a same-cycle
    // load to this address is seen only by later requests.
    always_comb begin
        in_entry.addr = req_addr;
        in_entry.oob  = (req_addr >> ADDR_W) != '0;
        in_entry.data = in_entry.oob ? NOP_WORD : store[req_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (ld_en) store[ld_addr] <= ld_data;
    end

    // LATENCY-1 register stages between acceptance and the FIFO push; with
    // LATENCY = 1 the read word is pushed at the acceptance edge itself.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept;
            assign push_entry = in_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] stg_valid;
            rsp_entry_t         stg_entry [LATENCY-1];

            always_ff @(posedge clk or negedge CPU_RESET_n) begin
                if (!CPU_RESET_n) begin
                    stg_valid <= '0;
                end else if (flush) begin
                    stg_valid <= '0;
                end else begin
                    stg_valid[0] <= accept;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        stg_valid[k] <= stg_valid[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                stg_entry[0] <= in_entry;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    stg_entry[k] <= stg_entry[k-1];
                end
            end

            assign push_valid = stg_valid[LATENCY-2];
            assign push_entry = stg_entry[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge CPU_RESET_n) begin
        if (!CPU_RESET_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, consume})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (CPU_RESET_n),
        .push  (push_valid && (!fifo_full || consume)),
        .din   (push_entry),
        .pop   (consume),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Outputs read as zero whenever no response is held, including reset.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = rsp_valid ? fifo_head.data : 16'h0000;
    assign rsp_addr  = rsp_valid ? fifo_head.addr : 16'h0000;
    assign rsp_oob   = rsp_valid && fifo_head.oob;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
// Directed scenario tasks with inline checks, plus a negedge scoreboard that
// queues the expected response for every accepted request (from a private
// copy of the program store) and compares each consumed response in order.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        CPU_RESET_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        rsp_oob;
    logic        flush;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] model_mem [256];
    logic [32:0] exp_q [$];

    imem_responder dut (
        .clk         (clk),
        .CPU_RESET_n (CPU_RESET_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_addr    (rsp_addr),
        .rsp_oob     (rsp_oob),
        .flush       (flush),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard: inputs change just after posedge, so at negedge the
    // handshakes show exactly what the next edge will do.
    always @(negedge clk) begin
        logic [32:0] got;
        logic [32:0] want;
        logic        oob;
        if (!CPU_RESET_n || flush) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                got = {rsp_data, rsp_addr, rsp_oob};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL scoreboard_extra: got %h, expected no response", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("[TB] FAIL scoreboard_order: got %h, expected %h", got, want);
                    end
                end
            end
            if (req_valid && req_ready) begin
                oob = (req_addr[15:8] != 8'h00);
                exp_q.push_back({oob ? 16'h2000 : model_mem[req_addr[7:0]], req_addr, oob});
            end
        end
        if (ld_en) model_mem[ld_addr] = ld_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        CPU_RESET_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) tick();
        #3;
        vectors++;
        if ({rsp_valid, req_ready, rsp_oob, rsp_data, rsp_addr} !== 35'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%b rdy=%b oob=%b d=%h a=%h, expected all zero",
                     rsp_valid, req_ready, rsp_oob, rsp_data, rsp_addr);
        end
        CPU_RESET_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", req_ready, rsp_valid);
        end
        tick();
    endtask

    task automatic load_program();
        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = 16'h1000 + 16'(i);
            tick();
        end
        ld_addr = 8'd3; ld_data = 16'h0A01; tick();
        ld_addr = 8'd5; ld_data = 16'h1234; tick();
        ld_en = 1'b0;
    endtask

    task automatic test_latency();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'd3;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL latency_ready: got %b, expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL latency_early: rsp_valid got %b at cycle 1, expected 0", rsp_valid);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_oob} !== {1'b1, 16'h0A01, 16'd3, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL latency_cycle2: got v=%b d=%h a=%h oob=%b, expected v=1 d=0a01 a=0003 oob=0",
                     rsp_valid, rsp_data, rsp_addr, rsp_oob);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL latency_drained: rsp_valid got %b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_addr = 16'(k);
            #1;
            vectors++;
            if (req_ready !== (k < 4)) begin
                miscompares++;
                $display("[TB] FAIL bp_ready_%0d: got %b, expected %b", k, req_ready, (k < 4));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({rsp_valid, rsp_addr, req_ready} !== {1'b1, 16'd0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold_%0d: got v=%b a=%h rdy=%b, expected v=1 a=0000 rdy=0",
                         k, rsp_valid, rsp_addr, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j == 2) req_valid = 1'b0;
            #1;
            vectors++;
            if ({rsp_valid, rsp_addr} !== {1'b1, 16'(j)}) begin
                miscompares++;
                $display("[TB] FAIL bp_drain_%0d: got v=%b a=%h, expected v=1 a=%h", j, rsp_valid, rsp_addr, 16'(j));
            end
            if (j == 1) begin
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL bp_reopen: req_ready got %b, expected 1", req_ready);
                end
            end
            tick();
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_empty: rsp_valid got %b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_oob();
        req_valid = 1'b1; req_addr = 16'h0100;
        tick();
        req_valid = 1'b0;
        tick();
        vectors++;
        if ({rsp_valid, rsp_data, rsp_addr, rsp_oob} !== {1'b1, 16'h2000, 16'h0100, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL oob_response: got v=%b d=%h a=%h oob=%b, expected v=1 d=2000 a=0100 oob=1",
                     rsp_valid, rsp_data, rsp_addr, rsp_oob);
        end
        tick();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'd1;
        tick();
        req_addr = 16'd2;
        tick();
        flush = 1'b1; req_addr = 16'd7;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_ready: got %b during flush, expected 0", req_ready);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL flush_after: got v=%b rdy=%b, expected v=0 rdy=1", rsp_valid, req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_stale_%0d: rsp_valid got %b, expected 0", k, rsp_valid);
            end
        end
        // Count must be back to zero: four requests fit with no consumer.
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 16'(8 + k);
            #1;
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL flush_count_%0d: req_ready got %b, expected 1", k, req_ready);
            end
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_read_before_write();
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = 16'hFFFF;
        req_valid = 1'b1; req_addr = 16'd5;
        tick();
        ld_en = 1'b0;
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 16'h1234}) begin
            miscompares++;
            $display("[TB] FAIL rbw_old: got v=%b d=%h, expected v=1 d=1234", rsp_valid, rsp_data);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 16'hFFFF}) begin
            miscompares++;
            $display("[TB] FAIL rbw_new: got v=%b d=%h, expected v=1 d=ffff", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int budget = 0;
        logic [15:0] addr;
        addr = 16'(($urandom_range(0, 3) == 0) ? 16'h0100 + 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 15)));
        while (issued < 12 && budget < 300) begin
            req_valid = 1'b1; req_addr = addr;
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (req_ready) begin
                issued++;
                addr = 16'(($urandom_range(0, 3) == 0) ? 16'h0100 + 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 15)));
            end
            tick();
            budget++;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        vectors++;
        if (issued != 12) begin
            miscompares++;
            $display("[TB] FAIL b2b_issue: issued %0d requests, expected 12", issued);
        end
        budget = 0;
        while ((exp_q.size() != 0 || rsp_valid) && budget < 30) begin
            tick();
            budget++;
        end
        vectors++;
        if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain: %0d responses still owed, rsp_valid=%b, expected 0 and 0",
                     exp_q.size(), rsp_valid);
        end
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = 16'(k);
            tick();
        end
        req_valid = 1'b0;
        #2;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL areset_pre: rsp_valid got %b, expected 1", rsp_valid);
        end
        CPU_RESET_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL areset_drop: got v=%b rdy=%b, expected v=0 rdy=0", rsp_valid, req_ready);
        end
        tick();
        #2;
        CPU_RESET_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL areset_ready: got %b, expected 1", req_ready);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL areset_stale_%0d: rsp_valid got %b, expected 0", k, rsp_valid);
            end
        end
    endtask

    initial begin
        $display("[TB] imem_responder bench start");
        test_reset();
        load_program();
        test_latency();
        test_back_pressure();
        test_oob();
        test_flush();
        test_read_before_write();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
